// File: rtl/riscv_pkg.sv
// Shared integer-core definitions: register-file geometry, register index type and
// the writeback source encoding used by the register-file writer.
package riscv_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned WIDTH      = 32;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;

  // Which producer owns the register-file write port in a given cycle
  typedef enum logic [1:0] {
    SrcNone,
    SrcLoad,
    SrcAlu,
    SrcOrphan
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle between the pipeline (ALU, load unit, decode) and the register-file writer.
interface regfile_writeback_if #(
  parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int unsigned WIDTH      = riscv_pkg::WIDTH
);

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0]      alu_data;
  logic                  alu_ready;
  logic                  ld_issue_valid;
  logic [ADDR_WIDTH-1:0] ld_issue_rd;
  logic                  ld_issue_ready;
  logic                  ld_done_valid;
  logic [WIDTH-1:0]      ld_done_data;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic [ADDR_WIDTH-1:0] rd;
  logic [WIDTH-1:0]      rd_wd;
  logic                  rd_we;
  logic                  err;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
           ld_done_valid, ld_done_data, rs1, rs2,
    input  alu_ready, ld_issue_ready, rs1_busy, rs2_busy, rd, rd_wd, rd_we, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
           ld_done_valid, ld_done_data, rs1, rs2,
    output alu_ready, ld_issue_ready, rs1_busy, rs2_busy, rd, rd_wd, rd_we, err
  );

endinterface

// File: rtl/pending_fifo.sv
// Synchronous FIFO of in-flight load destinations; head is visible combinationally.
module pending_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = riscv_pkg::ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra MSB separates full (MSBs differ) from empty (MSBs equal)
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PtrW-1] != r_rd_ptr[PtrW-1]) &&
                     (r_wr_ptr[PtrW-2:0] == r_rd_ptr[PtrW-2:0]);
  assign o_head    = r_mem[r_rd_ptr[PtrW-2:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PtrW-2:0]] <= i_din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writer: merges ALU results with in-order load completions and tracks
// registers with loads in flight for decode hazard detection.
module regfile_writeback #(
  parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter int unsigned WIDTH      = riscv_pkg::WIDTH,
  parameter int unsigned LOAD_DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  regfile_writeback_if.slave io_wb
);

  import riscv_pkg::*;

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  if (LOAD_DEPTH < 2 || (LOAD_DEPTH & (LOAD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("LOAD_DEPTH must be a power of two and at least 2");
  end

  logic [NumRegs-1:0]    r_busy;
  logic [NumRegs-1:0]    w_busy_d;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [ADDR_WIDTH-1:0] w_rd_d;
  logic [WIDTH-1:0]      r_rd_wd;
  logic [WIDTH-1:0]      w_rd_wd_d;
  logic                  r_rd_we;
  logic                  w_rd_we_d;
  logic                  r_rd_is_load;
  logic                  w_rd_is_load_d;
  logic                  r_err;
  logic                  w_err_d;

  logic [ADDR_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_alu_ready;
  logic                  w_ld_issue_ready;
  wb_src_e               w_src;

  assign w_ld_issue_ready = !w_full && !r_busy[io_wb.ld_issue_rd];
  assign w_alu_ready      = !io_wb.ld_done_valid && !r_busy[io_wb.alu_rd];
  assign w_push           = io_wb.ld_issue_valid && w_ld_issue_ready;
  assign w_pop            = io_wb.ld_done_valid && !w_empty;

  pending_fifo #(
    .DEPTH (LOAD_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_pending_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (io_wb.ld_issue_rd),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Load completion always wins the write port; it is never back-pressured
  always_comb begin
    w_src = SrcNone;
    if (io_wb.ld_done_valid) begin
      w_src = w_empty ? SrcOrphan : SrcLoad;
    end else if (io_wb.alu_valid && w_alu_ready) begin
      w_src = SrcAlu;
    end
  end

  always_comb begin
    w_rd_d         = r_rd;
    w_rd_wd_d      = r_rd_wd;
    w_rd_we_d      = 1'b0;
    w_rd_is_load_d = 1'b0;
    w_err_d        = r_err;
    case (w_src)
      SrcLoad: begin
        w_rd_d         = w_head;
        w_rd_wd_d      = io_wb.ld_done_data;
        w_rd_we_d      = (w_head != '0);
        w_rd_is_load_d = 1'b1;
      end
      SrcAlu: begin
        w_rd_d    = io_wb.alu_rd;
        w_rd_wd_d = io_wb.alu_data;
        w_rd_we_d = (io_wb.alu_rd != '0);
      end
      SrcOrphan: w_err_d = 1'b1;
      default: ;
    endcase
  end

  // Clear lands on the same edge that writes the loaded value into the register file
  always_comb begin
    w_busy_d = r_busy;
    if (r_rd_we && r_rd_is_load) w_busy_d[r_rd] = 1'b0;
    if (w_push && io_wb.ld_issue_rd != '0) w_busy_d[io_wb.ld_issue_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= '0;
      r_rd         <= '0;
      r_rd_wd      <= '0;
      r_rd_we      <= 1'b0;
      r_rd_is_load <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_busy       <= w_busy_d;
      r_rd         <= w_rd_d;
      r_rd_wd      <= w_rd_wd_d;
      r_rd_we      <= w_rd_we_d;
      r_rd_is_load <= w_rd_is_load_d;
      r_err        <= w_err_d;
    end
  end

  assign io_wb.alu_ready      = w_alu_ready;
  assign io_wb.ld_issue_ready = w_ld_issue_ready;
  assign io_wb.rs1_busy       = r_busy[io_wb.rs1];
  assign io_wb.rs2_busy       = r_busy[io_wb.rs2];
  assign io_wb.rd             = r_rd;
  assign io_wb.rd_wd          = r_rd_wd;
  assign io_wb.rd_we          = r_rd_we;
  assign io_wb.err            = r_err;

endmodule
